// File: rtl/sram_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : sram_arb_pkg
// Purpose : Shared encodings for the SRAM request arbiter. Contains the FSM
//           state type, the owner IDs and the access-size constants.
// Ports   : none (package)
// Options : ARB_ROUND_ROBIN_EN (used by arb_pick / sram_req_arbiter)
// Rev     : 1.0  initial release
// ============================================================================
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sram_req_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module  : arb_pick
// Purpose : Combinational grant selection between the instruction port (I)
//           and the load/store port (D).
// Ports   : inst_req, data_req - pending requests
//           ptr                - round-robin pointer (ARB_ROUND_ROBIN_EN only)
//           grant_valid        - at least one request pending
//           grant_owner        - OWN_I / OWN_D
// Options : ARB_ROUND_ROBIN_EN - when defined, ties go to the port named by
//           ptr; otherwise D always wins over I.
// Rev     : 1.0  initial release
// ============================================================================
module arb_pick
  import sram_arb_pkg::*;
(
  input  logic inst_req,
  input  logic data_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic ptr,
`endif
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = inst_req | data_req;
    grant_owner = OWN_I;
`ifdef ARB_ROUND_ROBIN_EN
    if (inst_req && data_req) begin
      grant_owner = ptr;
    end else if (data_req) begin
      grant_owner = OWN_D;
    end
`else
    if (data_req) begin
      grant_owner = OWN_D;
    end
`endif
  end

endmodule
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sram_req_arbiter
// Purpose : Shares one SRAM-like port between instruction fetch (inst_*) and
//           load/store (data_*). One transaction in flight; handshakes are
//           routed only to the owner of the current transaction.
// Ports   : clk, reset                 - clock, synchronous active-high reset
//           inst_req..inst_wdata       - instruction requester inputs
//           inst_addr_ok/data_ok/rdata - instruction requester responses
//           data_req..data_wdata       - load/store requester inputs
//           data_addr_ok/data_ok/rdata - load/store requester responses
//           mem_req..mem_wdata         - shared downstream request
//           mem_addr_ok/data_ok/rdata  - downstream responses
// Options : ARB_ROUND_ROBIN_EN - round-robin tie break instead of D-first.
// Rev     : 1.0  initial release
// ============================================================================
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_t state, state_nxt;
  logic   owner, owner_nxt;
  logic   grant_valid, grant_owner;

`ifdef ARB_ROUND_ROBIN_EN
  logic   rr_ptr, rr_ptr_nxt;

  arb_pick u_pick (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );
`else
  arb_pick u_pick (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= OWN_I;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr <= OWN_D;
`endif
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr <= rr_ptr_nxt;
`endif
    end
  end

  // All outputs default to zero; payload and handshakes are only opened up
  // in the state where they mean something, so idle/reset outputs are 0.
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
`ifdef ARB_ROUND_ROBIN_EN
    rr_ptr_nxt   = rr_ptr;
`endif
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = '0;
    mem_wstrb    = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;

    case (state)
      IDLE: begin
        // Grant is registered: a request never reaches mem_req in the
        // cycle it first appears.
        if (grant_valid) begin
          owner_nxt = grant_owner;
          state_nxt = REQ;
`ifdef ARB_ROUND_ROBIN_EN
          rr_ptr_nxt = ~rr_ptr;
`endif
        end
      end

      REQ: begin
        mem_req = 1'b1;
        if (owner == OWN_D) begin
          mem_wr    = data_wr;
          mem_size  = data_size;
          mem_wstrb = data_wstrb;
          mem_addr  = data_addr;
          mem_wdata = data_wdata;
        end else begin
          mem_wr    = inst_wr;
          mem_size  = inst_size;
          mem_wstrb = inst_wstrb;
          mem_addr  = inst_addr;
          mem_wdata = inst_wdata;
        end
        if (mem_addr_ok) begin
          data_addr_ok = (owner == OWN_D);
          inst_addr_ok = (owner == OWN_I);
          state_nxt    = RESP;
        end
      end

      RESP: begin
        if (mem_data_ok) begin
          if (owner == OWN_D) begin
            data_data_ok = 1'b1;
            data_rdata   = mem_rdata;
          end else begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_rdata;
          end
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire
